// File: rtl/serial_adder_nbit_if.sv
// Bus bundle for the bit-serial adder.
// Purpose : groups the start/operand request and the status/result response
//           of serial_adder_nbit so that a requester and the adder connect
//           through one port.
// Signals : start_in, a_in, b_in, cin_in          requester -> adder
//           ready_out, busy_out, done_out,
//           s_out, c_out                          adder -> requester
// Modports: master = requester side, slave = adder side.
interface serial_adder_nbit_if #(
  parameter int WIDTH = 8
);
  logic             start_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             ready_out;
  logic             busy_out;
  logic             done_out;
  logic [WIDTH-1:0] s_out;
  logic             c_out;

  modport master (
    output start_in, a_in, b_in, cin_in,
    input  ready_out, busy_out, done_out, s_out, c_out
  );

  modport slave (
    input  start_in, a_in, b_in, cin_in,
    output ready_out, busy_out, done_out, s_out, c_out
  );
endinterface

// File: rtl/serial_adder_nbit.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock.
// Purpose : {c_out,s_out} = a_in + b_in + cin_in computed over WIDTH SHIFT
//           cycles by a single full-adder cell (two half-adder cells plus an
//           OR of their carries) with a carry flip-flop between bits.
// Ports   : clk_in  rising-edge clock
//           rst_in  asynchronous active-high reset
//           bus     serial_adder_nbit_if.slave:
//                     start_in/a_in/b_in/cin_in  request, taken when ready_out=1
//                     ready_out  IDLE, busy_out  SHIFT, done_out  DONE (1 cycle)
//                     s_out/c_out result registers, updated on completion only
// Timing  : start taken at edge E -> done_out high in the cycle after E+WIDTH;
//           next start can be taken at E+WIDTH+2.

// 1-bit half-adder cell.
module serial_adder_half_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_adder_nbit #(
  parameter int WIDTH = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  serial_adder_nbit_if.slave bus
);
  // One extra counter bit keeps WIDTH=1 legal ($clog2(1) is 0).
  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nxt;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] s_q;
  logic             c_q;

  // Full-adder bit cell: ha0 adds the operand bits, ha1 folds in the carry.
  logic p, g, sum_bit, pc, carry_nxt;

  serial_adder_half_cell u_ha0 (.a(a_sh[0]), .b(b_sh[0]), .s(p),       .c(g));
  serial_adder_half_cell u_ha1 (.a(p),       .b(carry),   .s(sum_bit), .c(pc));

  // Both half-adder carries can never be 1 together, so OR is the majority.
  assign carry_nxt = g | pc;

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at LSB.
  always_comb begin
    sum_nxt            = sum_sh >> 1;
    sum_nxt[WIDTH-1]   = sum_bit;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state  <= S_IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      s_q    <= '0;
      c_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start_in) begin
            a_sh   <= bus.a_in;
            b_sh   <= bus.b_in;
            carry  <= bus.cin_in;
            sum_sh <= '0;
            cnt    <= '0;
            state  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + 1'b1;
          // Result registers load straight from the last bit's comb values,
          // so they are valid in the DONE cycle without an extra stage.
          if (cnt == LAST) begin
            s_q   <= sum_nxt;
            c_q   <= carry_nxt;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ready_out = (state == S_IDLE);
  assign bus.busy_out  = (state == S_SHIFT);
  assign bus.done_out  = (state == S_DONE);
  assign bus.s_out     = s_q;
  assign bus.c_out     = c_q;
endmodule
